// File: rtl/csi2_pkg.sv
// Shared types, constants and helper functions for the CSI-2 packet parser.
// Holds the header ECC parity masks and the reflected CRC-16 byte update.
package csi2_pkg;

  typedef enum logic [2:0] {
    S_HEADER,
    S_PAYLOAD,
    S_CRC_LO,
    S_CRC_HI,
    S_PHY_RST
  } state_t;

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_LINE_START  = 6'h02;
  localparam logic [5:0] DT_LINE_END    = 6'h03;
  localparam logic [5:0] DT_SHORT_MAX   = 6'h0F;

  localparam logic [23:0] ECC_MASK [6] = '{
    24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
  };

  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  function automatic logic [5:0] ecc_parity(input logic [23:0] d);
    logic [5:0] p;
    for (int i = 0; i < 6; i++) begin
      p[i] = ^(d & ECC_MASK[i]);
    end
    return p;
  endfunction

  // Data enters LSB-first, so the shift runs towards bit 0.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/csi2_crc16.sv
// Byte-serial CRC-16 register; init has priority over enable.
module csi2_crc16
  import csi2_pkg::*;
(
  input  logic        clock_p,
  input  logic        reset_n,
  input  logic        init,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc16_byte(crc_q, data);
    end
  end

  always_ff @(posedge clock_p) begin
    if (!reset_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/csi2_packet_parser.sv
// CSI-2 low-level protocol parser: header ECC check, packet classification,
// payload streaming with CRC-16 check, and PHY re-hunt reset after each packet.
module csi2_packet_parser
  import csi2_pkg::*;
#(
  parameter int RESET_CYCLES = 4
) (
  input  logic        clock_p,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        phy_reset,
  output logic        header_valid,
  output logic [1:0]  virtual_channel,
  output logic [5:0]  data_type,
  output logic [15:0] word_count,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_start,
  output logic        line_end,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        packet_done,
  output logic        ecc_error,
  output logic        crc_error
);

  localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  hdr_cnt_q;
  logic [3:0]  rst_cnt_q;
  logic [15:0] remaining_q;
  logic [7:0]  di_q, wc_lo_q, wc_hi_q, crc_lo_q;
  logic        phy_reset_q, header_valid_q, payload_valid_q, payload_last_q;
  logic        frame_start_q, frame_end_q, line_start_q, line_end_q;
  logic        packet_done_q, ecc_error_q, crc_error_q;
  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic [7:0]  payload_data_q;

  logic [15:0] crc_calc;
  logic [5:0]  syndrome_d;
  logic        hdr_ok_d, hdr_done_d, crc_en_d;
  logic [5:0]  dt_d;
  logic [15:0] wc_d;

  assign dt_d       = di_q[5:0];
  assign wc_d       = {wc_hi_q, wc_lo_q};
  assign syndrome_d = ecc_parity({wc_hi_q, wc_lo_q, di_q}) ^ byte_data[5:0];
  assign hdr_ok_d   = (syndrome_d == 6'd0) && (byte_data[7:6] == 2'b00);
  assign hdr_done_d = (state_q == S_HEADER) && byte_valid && (hdr_cnt_q == 2'd3);
  assign crc_en_d   = (state_q == S_PAYLOAD) && byte_valid;

  csi2_crc16 u_crc (
    .clock_p (clock_p),
    .reset_n (reset_n),
    .init    (hdr_done_d),
    .enable  (crc_en_d),
    .data    (byte_data),
    .crc     (crc_calc)
  );

  always_ff @(posedge clock_p) begin
    if (!reset_n) begin
      state_q         <= S_HEADER;
      hdr_cnt_q       <= 2'd0;
      rst_cnt_q       <= 4'd0;
      remaining_q     <= 16'd0;
      di_q            <= 8'd0;
      wc_lo_q         <= 8'd0;
      wc_hi_q         <= 8'd0;
      crc_lo_q        <= 8'd0;
      phy_reset_q     <= 1'b1;
      header_valid_q  <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      line_start_q    <= 1'b0;
      line_end_q      <= 1'b0;
      packet_done_q   <= 1'b0;
      ecc_error_q     <= 1'b0;
      crc_error_q     <= 1'b0;
      vc_q            <= 2'd0;
      dt_q            <= 6'd0;
      wc_q            <= 16'd0;
      payload_data_q  <= 8'd0;
    end else begin
      header_valid_q  <= 1'b0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      line_start_q    <= 1'b0;
      line_end_q      <= 1'b0;
      packet_done_q   <= 1'b0;
      ecc_error_q     <= 1'b0;
      crc_error_q     <= 1'b0;

      case (state_q)
        S_HEADER: begin
          phy_reset_q <= 1'b0;
          if (byte_valid) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
            case (hdr_cnt_q)
              2'd0: di_q    <= byte_data;
              2'd1: wc_lo_q <= byte_data;
              2'd2: wc_hi_q <= byte_data;
              default: begin
                if (!hdr_ok_d) begin
                  ecc_error_q   <= 1'b1;
                  packet_done_q <= 1'b1;
                  phy_reset_q   <= 1'b1;
                  rst_cnt_q     <= 4'd0;
                  state_q       <= S_PHY_RST;
                end else begin
                  header_valid_q <= 1'b1;
                  vc_q           <= di_q[7:6];
                  dt_q           <= dt_d;
                  wc_q           <= wc_d;
                  if (dt_d <= DT_SHORT_MAX) begin
                    frame_start_q <= (dt_d == DT_FRAME_START);
                    frame_end_q   <= (dt_d == DT_FRAME_END);
                    line_start_q  <= (dt_d == DT_LINE_START);
                    line_end_q    <= (dt_d == DT_LINE_END);
                    packet_done_q <= 1'b1;
                    phy_reset_q   <= 1'b1;
                    rst_cnt_q     <= 4'd0;
                    state_q       <= S_PHY_RST;
                  end else if (wc_d != 16'd0) begin
                    remaining_q <= wc_d;
                    state_q     <= S_PAYLOAD;
                  end else begin
                    state_q <= S_CRC_LO;
                  end
                end
              end
            endcase
          end
        end

        S_PAYLOAD: begin
          if (byte_valid) begin
            payload_data_q  <= byte_data;
            payload_valid_q <= 1'b1;
            remaining_q     <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              payload_last_q <= 1'b1;
              state_q        <= S_CRC_LO;
            end
          end
        end

        S_CRC_LO: begin
          if (byte_valid) begin
            crc_lo_q <= byte_data;
            state_q  <= S_CRC_HI;
          end
        end

        S_CRC_HI: begin
          if (byte_valid) begin
            packet_done_q <= 1'b1;
            crc_error_q   <= ({byte_data, crc_lo_q} != crc_calc);
            phy_reset_q   <= 1'b1;
            rst_cnt_q     <= 4'd0;
            state_q       <= S_PHY_RST;
          end
        end

        S_PHY_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            phy_reset_q <= 1'b0;
            hdr_cnt_q   <= 2'd0;
            state_q     <= S_HEADER;
          end else begin
            rst_cnt_q <= rst_cnt_q + 4'd1;
          end
        end

        default: state_q <= S_HEADER;
      endcase
    end
  end

  assign phy_reset       = phy_reset_q;
  assign header_valid    = header_valid_q;
  assign virtual_channel = vc_q;
  assign data_type       = dt_q;
  assign word_count      = wc_q;
  assign frame_start     = frame_start_q;
  assign frame_end       = frame_end_q;
  assign line_start      = line_start_q;
  assign line_end        = line_end_q;
  assign payload_data    = payload_data_q;
  assign payload_valid   = payload_valid_q;
  assign payload_last    = payload_last_q;
  assign packet_done     = packet_done_q;
  assign ecc_error       = ecc_error_q;
  assign crc_error       = crc_error_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Self-checking bench for csi2_packet_parser: table of short headers plus
// long-packet, CRC-error, zero-length and mid-payload-reset sequences.
module tb_csi2_packet_parser;

  logic        clock_p = 1'b0;
  logic        reset_n;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        phy_reset, header_valid, frame_start, frame_end, line_start, line_end;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic [7:0]  payload_data;
  logic        payload_valid, payload_last, packet_done, ecc_error, crc_error;

  always #5 clock_p = ~clock_p;

  csi2_packet_parser #(.RESET_CYCLES(4)) dut (
    .clock_p(clock_p), .reset_n(reset_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .phy_reset(phy_reset), .header_valid(header_valid), .virtual_channel(virtual_channel),
    .data_type(data_type), .word_count(word_count), .frame_start(frame_start),
    .frame_end(frame_end), .line_start(line_start), .line_end(line_end),
    .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last),
    .packet_done(packet_done), .ecc_error(ecc_error), .crc_error(crc_error)
  );

  typedef struct {
    logic [31:0] hdr;
    logic        hv;
    logic [3:0]  ev;
    logic        ecc;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } pl_t;

  int  pass_cnt = 0, total_cnt = 0;
  int  hv_seen, pd_seen, ecc_seen, crc_seen, pv_seen, rst_run, last_rst_len;
  logic [3:0] ev_seen;
  pl_t exp_q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [23:0] m [6];
    logic [7:0] e;
    m = '{24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00};
    e = 8'h00;
    for (int i = 0; i < 6; i++) e[i] = ^(d & m[i]);
    return e;
  endfunction

  function automatic logic [31:0] mk_hdr(input logic [7:0] di, input logic [15:0] wc);
    return {ecc_of({wc, di}), wc[15:8], wc[7:0], di};
  endfunction

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic sample();
    hv_seen  += int'(header_valid);
    pd_seen  += int'(packet_done);
    ecc_seen += int'(ecc_error);
    crc_seen += int'(crc_error);
    ev_seen  = ev_seen | {line_end, line_start, frame_end, frame_start};
    if (phy_reset) rst_run++;
    else if (rst_run != 0) begin
      last_rst_len = rst_run;
      rst_run = 0;
    end
    if (packet_done) chk("done_with_phy_reset", phy_reset, 1);
    if (crc_error) chk("crc_error_with_done", packet_done, 1);
    if (payload_valid) begin
      pv_seen++;
      if (exp_q.size() == 0) begin
        chk("payload_unexpected", 1, 0);
      end else begin
        pl_t e;
        e = exp_q.pop_front();
        chk("payload_data", payload_data, e.d);
        chk("payload_last", payload_last, e.last);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b);
    @(negedge clock_p);
    sample();
    byte_valid = v;
    byte_data  = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cyc(1'b1, b);
    repeat (3) cyc(1'b0, 8'h00);
  endtask

  task automatic send_hdr(input logic [31:0] h);
    for (int i = 0; i < 4; i++) send_byte(h[8*i +: 8]);
  endtask

  task automatic clr();
    hv_seen = 0; pd_seen = 0; ecc_seen = 0; crc_seen = 0; pv_seen = 0;
    ev_seen = 4'd0; last_rst_len = 0;
  endtask

  task automatic run_long(input logic [31:0] hdr, input int n, input logic flip);
    logic [15:0] c;
    logic [7:0] b;
    c = 16'hFFFF;
    clr();
    send_hdr(hdr);
    for (int i = 0; i < n; i++) begin
      b = 8'((i + 1) * 17);
      c = crc_bit(c, b);
      exp_q.push_back('{d: b, last: (i == n - 1)});
      send_byte(b);
    end
    send_byte(c[7:0] ^ {7'd0, flip});
    send_byte(c[15:8]);
    repeat (12) cyc(1'b0, 8'h00);
  endtask

  initial begin
    reset_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    rst_run = 0;
    clr();
    repeat (3) cyc(1'b0, 8'h00);
    chk("reset_phy_reset", phy_reset, 1);
    chk("reset_outputs", {header_valid, frame_start, frame_end, line_start, line_end,
        payload_valid, payload_last, packet_done, ecc_error, crc_error,
        virtual_channel, data_type, word_count, payload_data}, 64'd0);
    reset_n = 1'b1;
    repeat (4) cyc(1'b0, 8'h00);
    chk("phy_reset_released", phy_reset, 0);

    vecs[0] = '{32'h1A000100, 1'b1, 4'b0001, 1'b0, 2'd0, 6'h00, 16'h0001};
    vecs[1] = '{32'h1B000100, 1'b0, 4'b0000, 1'b1, 2'd0, 6'h00, 16'h0001};
    vecs[2] = '{mk_hdr(8'h41, 16'h1234), 1'b1, 4'b0010, 1'b0, 2'd1, 6'h01, 16'h1234};
    vecs[3] = '{mk_hdr(8'h82, 16'h0005), 1'b1, 4'b0100, 1'b0, 2'd2, 6'h02, 16'h0005};
    vecs[4] = '{mk_hdr(8'hC3, 16'hFFFF), 1'b1, 4'b1000, 1'b0, 2'd3, 6'h03, 16'hFFFF};
    vecs[5] = '{mk_hdr(8'h0F, 16'h0010), 1'b1, 4'b0000, 1'b0, 2'd0, 6'h0F, 16'h0010};
    vecs[6] = '{mk_hdr(8'h04, 16'h0000), 1'b1, 4'b0000, 1'b0, 2'd0, 6'h04, 16'h0000};
    vecs[7] = '{mk_hdr(8'h00, 16'h0002) | 32'h40000000, 1'b0, 4'b0000, 1'b1, 2'd0, 6'h04, 16'h0000};
    vecs[8] = '{mk_hdr(8'h01, 16'h0000) ^ 32'h00000100, 1'b0, 4'b0000, 1'b1, 2'd0, 6'h04, 16'h0000};

    for (int v = 0; v < 9; v++) begin
      clr();
      send_hdr(vecs[v].hdr);
      repeat (12) cyc(1'b0, 8'h00);
      chk($sformatf("v%0d_header_valid", v), hv_seen, vecs[v].hv);
      chk($sformatf("v%0d_events", v), ev_seen, vecs[v].ev);
      chk($sformatf("v%0d_ecc_error", v), ecc_seen, vecs[v].ecc);
      chk($sformatf("v%0d_packet_done", v), pd_seen, 1);
      chk($sformatf("v%0d_fields", v), {virtual_channel, data_type, word_count},
          {vecs[v].vc, vecs[v].dt, vecs[v].wc});
      chk($sformatf("v%0d_phy_reset_len", v), last_rst_len, 4);
      chk($sformatf("v%0d_no_payload", v), pv_seen, 0);
    end

    run_long(32'h3300042A, 4, 1'b0);
    chk("raw8_header_valid", hv_seen, 1);
    chk("raw8_payload_count", pv_seen, 4);
    chk("raw8_crc_error", crc_seen, 0);
    chk("raw8_packet_done", pd_seen, 1);
    chk("raw8_fields", {data_type, word_count}, {6'h2A, 16'h0004});
    chk("raw8_phy_reset_len", last_rst_len, 4);

    run_long(32'h3300042A, 4, 1'b1);
    chk("badcrc_payload_count", pv_seen, 4);
    chk("badcrc_crc_error", crc_seen, 1);
    chk("badcrc_packet_done", pd_seen, 1);

    run_long(mk_hdr(8'h2A, 16'h0000), 0, 1'b0);
    chk("wc0_header_valid", hv_seen, 1);
    chk("wc0_payload_count", pv_seen, 0);
    chk("wc0_crc_error", crc_seen, 0);
    chk("wc0_packet_done", pd_seen, 1);
    chk("wc0_phy_reset_len", last_rst_len, 4);

    clr();
    send_hdr(mk_hdr(8'h2A, 16'h0008));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{d: 8'(8'hA0 + i), last: 1'b0});
      send_byte(8'(8'hA0 + i));
    end
    reset_n = 1'b0;
    cyc(1'b0, 8'h00);
    chk("midrst_phy_reset", phy_reset, 1);
    cyc(1'b0, 8'h00);
    reset_n = 1'b1;
    repeat (6) cyc(1'b0, 8'h00);
    chk("midrst_no_done", pd_seen, 0);
    chk("midrst_no_errors", {ecc_seen[7:0], crc_seen[7:0]}, 16'd0);
    chk("midrst_payload_count", pv_seen, 3);

    run_long(32'h3300042A, 4, 1'b0);
    chk("post_rst_header_valid", hv_seen, 1);
    chk("post_rst_payload_count", pv_seen, 4);
    chk("post_rst_crc_error", crc_seen, 0);
    chk("post_rst_packet_done", pd_seen, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
